// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC requests, in-order response buffering,
// and redirect handling that flushes the queue and drops stale in-flight responses.
module fetch_queue #(
   parameter int unsigned    XLEN     = 32,
   parameter int unsigned    ADDR_W   = 16,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_resp_valid,
   input  logic [XLEN-1:0]   imem_resp_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_instr,
   output logic [XLEN-1:0]   out_pc
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_rsp_pc;
   logic [XLEN-1:0] r_instr [DEPTH];
   logic [XLEN-1:0] r_ipc   [DEPTH];
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_tail;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   r_out;
   logic [CW-1:0]   r_drop;

   logic            w_credit_ok;
   logic            w_fire;
   logic            w_drop;
   logic            w_enq;
   logic            w_deq;
   logic [CW-1:0]   w_out_nxt;
   logic [XLEN-1:0] w_redir_pc;

   // Every accepted request owns a queue slot until its response is consumed or dropped
   assign w_credit_ok = (r_out < CW'(DEPTH)) &&
                        (((CW+1)'(r_cnt) + (CW+1)'(r_out) - (CW+1)'(r_drop)) < (CW+1)'(DEPTH));

   assign imem_req_valid = rst_n & ~redirect & w_credit_ok;
   assign imem_req_addr  = r_pc[ADDR_W-1:0];

   assign w_fire     = imem_req_valid & imem_req_ready;
   assign w_drop     = imem_resp_valid & (redirect | (r_drop != '0));
   assign w_enq      = imem_resp_valid & ~w_drop;
   assign w_deq      = out_valid & out_ready & ~redirect;
   assign w_out_nxt  = r_out + CW'(w_fire) - CW'(imem_resp_valid);
   assign w_redir_pc = redirect_pc & ~XLEN'(3);

   assign out_valid = (r_cnt != '0);
   assign out_instr = r_instr[r_head];
   assign out_pc    = r_ipc[r_head];

   // r_rsp_pc is the PC of the next response that will be kept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= RESET_PC;
         r_rsp_pc <= RESET_PC;
         r_head   <= '0;
         r_tail   <= '0;
         r_cnt    <= '0;
         r_out    <= '0;
         r_drop   <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_instr[i] <= '0;
            r_ipc[i]   <= '0;
         end
      end else begin
         r_out <= w_out_nxt;
         if (redirect) begin
            r_pc     <= w_redir_pc;
            r_rsp_pc <= w_redir_pc;
            r_head   <= '0;
            r_tail   <= '0;
            r_cnt    <= '0;
            r_drop   <= w_out_nxt;
         end else begin
            if (w_fire) begin
               r_pc <= r_pc + XLEN'(4);
            end
            if (w_enq) begin
               r_instr[r_tail] <= imem_resp_data;
               r_ipc[r_tail]   <= r_rsp_pc;
               r_tail          <= r_tail + PW'(1);
               r_rsp_pc        <= r_rsp_pc + XLEN'(4);
            end
            if (w_deq) begin
               r_head <= r_head + PW'(1);
            end
            r_cnt <= r_cnt + CW'(w_enq) - CW'(w_deq);
            if (imem_resp_valid && (r_drop != '0)) begin
               r_drop <= r_drop - CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: latency-programmable memory model, expected PC stream
// rebuilt from the redirect history, and a monitor that checks every decode handshake.
module tb_fetch_queue;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              redirect = 1'b0;
   logic [XLEN-1:0]   redirect_pc = '0;
   logic              imem_req_valid;
   logic              imem_req_ready = 1'b1;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_resp_valid = 1'b0;
   logic [XLEN-1:0]   imem_resp_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [XLEN-1:0]   out_instr;
   logic [XLEN-1:0]   out_pc;

   fetch_queue #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pc          (out_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      int unsigned       due;
   } req_t;

   int          n_cmp   = 0;
   int          n_err   = 0;
   int          n_deliv = 0;
   int          lat     = 1;
   int          rdy_pct = 100;
   int unsigned cyc     = 0;
   req_t        pend[$];
   logic [31:0] exp_q[$];
   logic [31:0] model_pc = '0;

   function automatic logic [31:0] rom(input logic [ADDR_W-1:0] a);
      return 32'h1000 + 32'(a[ADDR_W-1:2]);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // Expected decode stream: consecutive PCs from the last reset/redirect target
   task automatic refill();
      while (exp_q.size() < 16) begin
         exp_q.push_back(model_pc);
         model_pc = model_pc + 32'd4;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      refill();
   endtask

   task automatic redir(input logic [31:0] t);
      redirect    = 1'b1;
      redirect_pc = t;
      exp_q.delete();
      model_pc = t & ~32'h3;
      refill();
      tick();
      redirect = 1'b0;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      redirect  = 1'b0;
      out_ready = 1'b0;
      exp_q.delete();
      model_pc = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_req_valid", 32'(imem_req_valid), 32'd0);
         if (i == 2) begin
            check("rst_out_pc", out_pc, 32'd0);
            check("rst_out_instr", out_instr, 32'd0);
         end
         tick();
      end
      rst_n = 1'b1;
   endtask

   // Memory: in-order responses, lat cycles after acceptance, cleared by reset
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend.delete();
         end else if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{imem_req_addr, cyc + 32'(lat)});
         end
         @(posedge clk);
         cyc++;
         #1;
         imem_req_ready = ($urandom_range(99) < rdy_pct);
         if (rst_n && pend.size() != 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = rom(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
         end
         if (rst_n) begin
            check("outstanding_le_depth",
                  32'((pend.size() + int'(imem_resp_valid)) <= int'(DEPTH)), 32'd1);
         end
      end
   end

   // Monitor: every decode handshake must match the head of the expected stream
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (redirect) begin
               check("req_during_redirect", 32'(imem_req_valid), 32'd0);
            end else if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  fail_now("scoreboard_empty");
               end else begin
                  e = exp_q.pop_front();
                  check("out_pc", out_pc, e);
                  check("out_instr", out_instr, rom(e[ADDR_W-1:0]));
                  n_deliv++;
               end
            end
         end
      end
   end

   initial begin
      int nf;
      int start;
      bit found;

      // Reset, first fetch addresses, then bubble-free streaming
      rdy_pct = 100;
      lat     = 1;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t1_req_valid", 32'(imem_req_valid), 32'd1);
         check("t1_req_addr", 32'(imem_req_addr), 32'(4 * i));
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t2_stream_valid", 32'(out_valid), 32'd1);
         tick();
      end

      // Backpressure: exactly DEPTH requests, then release and resume at 0x10
      do_reset();
      nf = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) nf++;
         tick();
      end
      check("t3_req_count", 32'(nf), 32'(DEPTH));
      @(negedge clk);
      check("t3_req_stalled", 32'(imem_req_valid), 32'd0);
      check("t3_queue_full", 32'(out_valid), 32'd1);
      tick();
      out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (imem_req_valid) begin
            found = 1'b1;
            check("t3_resume_addr", 32'(imem_req_addr), 32'h10);
         end
         tick();
      end
      if (!found) fail_now("t3_resume");

      // Redirect with responses in flight at latency 3
      do_reset();
      lat       = 3;
      out_ready = 1'b1;
      repeat (12) tick();
      start = n_deliv;
      redir(32'h40);
      for (int i = 0; i < 30 && n_deliv == start; i++) tick();
      if (n_deliv == start) fail_now("t4_resume");
      repeat (8) tick();

      // Redirect coinciding with a response and a dequeue
      lat = 1;
      repeat (6) tick();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         #1;
         if (imem_resp_valid && out_valid) found = 1'b1;
         else tick();
      end
      if (!found) fail_now("t5_setup");
      redir(32'h40);
      @(negedge clk);
      check("t5_out_valid", 32'(out_valid), 32'd0);
      check("t5_req_valid", 32'(imem_req_valid), 32'd1);
      check("t5_req_addr", 32'(imem_req_addr), 32'h40);
      repeat (6) tick();

      // Unaligned redirect target
      redir(32'h43);
      @(negedge clk);
      check("t6_req_valid", 32'(imem_req_valid), 32'd1);
      check("t6_req_addr", 32'(imem_req_addr), 32'h40);
      repeat (6) tick();

      // PC wrap at the top of the address space
      redir(32'hFFFF_FFFC);
      @(negedge clk);
      check("t7_req_addr0", 32'(imem_req_addr), 32'hFFFC);
      tick();
      @(negedge clk);
      check("t7_req_addr1", 32'(imem_req_addr), 32'h0000);
      repeat (8) tick();

      // Randomized traffic
      rdy_pct = 70;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) lat = int'($urandom_range(4, 1));
         out_ready = ($urandom_range(99) < 70);
         if ($urandom_range(24) == 0) begin
            redir(($urandom_range(7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(15))
                                           : 32'($urandom_range(1023)));
         end else begin
            tick();
         end
      end

      // Drain: forward progress with everything ready
      rdy_pct   = 100;
      lat       = 1;
      out_ready = 1'b1;
      start     = n_deliv;
      for (int i = 0; i < 200 && n_deliv < start + 20; i++) tick();
      check("drain_progress", 32'(n_deliv >= start + 20), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
